simon_serial_adder: RTL and testbench

- Responder-side DUT for the simon_interface adder channel: it receives x, y and cin and returns sum and cout.
- Computes the add bit-serially with one full-adder slice, LSB first, so the bench exercises real multi-cycle latency and backpressure instead of a combinational path.
- Sits between the bench driver (operand side) and the bench monitor (result side).
- Serves as the arithmetic primitive that later Simon round logic builds on.

---
 rtl/simon_serial_adder.sv | 109 ++++++++++
 tb/tb_simon_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/simon_serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first; result registered WIDTH edges after accept.
// Backpressure: result held in HOLD until out_ready; in_ready low whenever busy.
module simon_serial_adder #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [CNT_W-1:0] ops_done
);

   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [WIDTH-1:0] xa;
   logic [WIDTH-1:0] ya;
   logic [WIDTH-1:0] sa;
   logic             c;
   logic [KW-1:0]    k;
   logic             s;
   logic             c_nxt;
   logic             last;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid && in_ready) state_nxt = ADD;
         ADD:     if (last) state_nxt = HOLD;
         HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE) && reset;
      s        = xa[0] ^ ya[0] ^ c;
      c_nxt    = (xa[0] & ya[0]) | (xa[0] & c) | (ya[0] & c);
      last     = (state == ADD) && (k == KW'(WIDTH - 1));
   end

   // Operands are captured only on an accepted handshake, so x/y noise while idle never lands.
   always_ff @(posedge clk) begin
      if (!reset) begin
         xa        <= '0;
         ya        <= '0;
         sa        <= '0;
         c         <= 1'b0;
         k         <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
         ops_done  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  xa <= x;
                  ya <= y;
                  c  <= cin;
                  sa <= '0;
                  k  <= '0;
               end
            end
            ADD: begin
               xa <= xa >> 1;
               ya <= ya >> 1;
               c  <= c_nxt;
               sa <= {s, sa[WIDTH-1:1]};
               k  <= k + KW'(1);
               if (last) begin
                  sum       <= {s, sa[WIDTH-1:1]};
                  cout      <= c_nxt;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  ops_done  <= ops_done + CNT_W'(1);
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simon_serial_adder.sv
// Directed and streamed checks for simon_serial_adder (WIDTH=4, CNT_W=8).
module tb_simon_serial_adder;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [CNT_W-1:0] ops_done;

   int n_checks = 0;
   int n_errors = 0;
   int exp_ops  = 0;

   always #5 clk = ~clk;

   simon_serial_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ops_done  (ops_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
      in_valid = 1'b1;
      x        = a;
      y        = b;
      cin      = ci;
   endtask

   // Called at the negedge where operands were just driven; returns at the negedge
   // after the edge that enters HOLD. drop_valid=0 keeps in_valid high with x=1.
   task automatic expect_result(input string tag, input logic [WIDTH-1:0] es,
                                input logic ec, input bit drop_valid);
      for (int i = 0; i <= WIDTH; i++) begin
         @(negedge clk);
         if (i < WIDTH) begin
            check({tag, "_busy_valid"}, out_valid, 0);
            check({tag, "_busy_ready"}, in_ready, 0);
         end else begin
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_sum"}, sum, es);
            check({tag, "_cout"}, cout, ec);
         end
         if (i == 0) begin
            if (drop_valid) begin
               in_valid = 1'b0;
               x        = 'x;
               y        = 'x;
            end else begin
               x   = 4'h1;
               y   = 4'h0;
               cin = 1'b0;
            end
         end
      end
   endtask

   task automatic handoff_check(input string tag);
      @(negedge clk);
      exp_ops = (exp_ops + 1) % (1 << CNT_W);
      check({tag, "_drop_valid"}, out_valid, 0);
      check({tag, "_idle_ready"}, in_ready, 1);
      check({tag, "_ops_done"}, ops_done, exp_ops);
   endtask

   task automatic op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic ci, input logic [WIDTH-1:0] es, input logic ec);
      check({tag, "_start_ready"}, in_ready, 1);
      drive(a, b, ci);
      expect_result(tag, es, ec, 1'b1);
      handoff_check(tag);
   endtask

   initial begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             ci;
      logic [WIDTH:0]   ref_sum;
      int               n;

      // Reset held with a request pending.
      reset     = 1'b0;
      in_valid  = 1'b1;
      x         = 4'h5;
      y         = 4'h0;
      cin       = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ops", ops_done, 0);
      check("rst_ready", in_ready, 0);
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", in_ready, 1);
      check("post_rst_valid", out_valid, 0);

      out_ready = 1'b1;
      op("basic", 4'h3, 4'h5, 1'b0, 4'h8, 1'b0);
      op("carry_f1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
      op("carry_ff1", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
      op("cin_only", 4'h0, 4'h0, 1'b1, 4'h1, 1'b0);
      op("wrap", 4'hF, 4'h0, 1'b1, 4'h0, 1'b1);

      // Backpressure with in_valid held high and new operands waiting.
      out_ready = 1'b0;
      check("bp_start_ready", in_ready, 1);
      drive(4'h7, 4'h7, 1'b0);
      expect_result("bp", 4'hE, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_sum", sum, 4'hE);
         check("bp_hold_cout", cout, 0);
         check("bp_hold_ready", in_ready, 0);
         check("bp_hold_ops", ops_done, exp_ops);
      end
      out_ready = 1'b1;
      handoff_check("bp");
      expect_result("bp_next", 4'h1, 1'b0, 1'b1);
      handoff_check("bp_next");

      // Reset during the second ADD cycle.
      drive(4'h9, 4'h9, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      exp_ops = 0;
      for (int i = 0; i < WIDTH + 2; i++) begin
         @(negedge clk);
         check("abort_valid", out_valid, 0);
         check("abort_sum", sum, 0);
         check("abort_cout", cout, 0);
         check("abort_ops", ops_done, 0);
         check("abort_ready", in_ready, 1);
      end
      op("after_abort", 4'h2, 4'h3, 1'b0, 4'h5, 1'b0);

      // Back-to-back stream; ops_done must wrap after 256 handoffs.
      reset = 1'b0;
      @(negedge clk);
      reset     = 1'b1;
      exp_ops   = 0;
      out_ready = 1'b1;
      @(negedge clk);
      for (int op_i = 0; op_i < 256; op_i++) begin
         a  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
         b  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
         ci = 1'($urandom_range(0, 1));
         ref_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
         check("stream_ready", in_ready, 1);
         drive(a, b, ci);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!out_valid && n < 4 * WIDTH);
         // WIDTH+1 negedges after driving = WIDTH edges after accept; handoff one edge later.
         check("stream_latency", n, WIDTH + 1);
         check("stream_sum", sum, ref_sum[WIDTH-1:0]);
         check("stream_cout", cout, ref_sum[WIDTH]);
         @(negedge clk);
         exp_ops = (exp_ops + 1) % (1 << CNT_W);
         check("stream_pulse", out_valid, 0);
         check("stream_ops", ops_done, exp_ops);
      end
      check("stream_wrap", ops_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
